// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_pkg                                                   |
// | Description : Shared UART definitions (FSM state encoding, default bit   |
// |               period, data width, parity helper) for the TX and RX side. |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package uart_pkg;

   localparam int UART_DATA_W           = 8;
   localparam int UART_CLKS_PER_BIT_DEF = 434;   // 50 MHz / 115200 baud

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [UART_DATA_W-1:0] i_d);
      return ^i_d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                             |
// | Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and pulses    |
// |               o_tick for one cycle on the last count of each bit.        |
// | Ports       : clk       - clock, rising edge                             |
// |               rst       - asynchronous active-high reset                 |
// |               i_restart - hold/restart the counter at 0                  |
// |               o_tick    - one-cycle bit-end pulse                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int                 c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // Wrapping on the tick restarts the count at every bit boundary, so bit
   // periods never accumulate drift across a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_restart || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx                                                    |
// | Description : UART transmitter, 8 data bits LSB first, 1 or 2 stop bits. |
// |               Optional even parity bit when UART_TX_PARITY_EN is defined.|
// | Ports       : CLOCK     - clock, rising edge                             |
// |               RESET     - asynchronous active-high reset                 |
// |               tx_data   - byte to send, sampled at handshake             |
// |               tx_valid  - upstream byte available                        |
// |               tx_ready  - block can accept a byte (IDLE)                 |
// |               tx_serial - registered UART line, idle high                |
// |               tx_busy   - frame in progress (~tx_ready)                  |
// | Macros      : UART_TX_PARITY_EN - add even parity bit after bit 7        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int STOP_BITS    = 1
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic [UART_DATA_W-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic                   tx_serial,
   output logic                   tx_busy
);

   localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);

   uart_state_t            r_state, w_state_nxt;
   logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
   logic [2:0]             r_bit_idx, w_bit_idx_nxt;
   logic                   r_serial, w_serial_nxt;
   logic                   w_tick;
   logic                   w_accept;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity, w_parity_nxt;
`endif

   // Counter is held at 0 while idle so START lasts exactly one bit period.
   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk       (CLOCK),
      .rst       (RESET),
      .i_restart (r_state == ST_IDLE),
      .o_tick    (w_tick)
   );

   assign w_accept = tx_valid && (r_state == ST_IDLE);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_serial  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_serial  <= w_serial_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;
      w_serial_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt  = r_parity;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt   = ST_START;
               w_shift_nxt   = tx_data;
               w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
               // Captured now because the shift register is consumed bit by bit.
               w_parity_nxt  = even_parity(tx_data);
`endif
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt   = ST_PARITY;
`else
                  w_state_nxt   = ST_STOP;
`endif
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_shift_nxt   = {1'b0, r_shift[UART_DATA_W-1:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Bit index is reused to count stop bits.
            if (w_tick) begin
               if (r_bit_idx == c_last_stop) begin
                  w_state_nxt   = ST_IDLE;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Line value is derived from the next state so tx_serial is a clean
      // register output aligned with the state it belongs to.
      case (w_state_nxt)
         ST_START:  w_serial_nxt = 1'b0;
         ST_DATA:   w_serial_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_serial_nxt = w_parity_nxt;
`endif
         default:   w_serial_nxt = 1'b1;
      endcase
   end

   assign tx_ready  = (r_state == ST_IDLE);
   assign tx_busy   = ~tx_ready;
   assign tx_serial = r_serial;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), giving the CLOCK cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits; legal values 1 or 2.
REQ-003 The block SHALL have port CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port tx_data  input  8  byte to transmit, sampled at handshake.
REQ-006 The block SHALL have port tx_valid  input  1  upstream asserts when tx_data holds a byte to send.
REQ-007 The block SHALL have port tx_ready  output  1  high when the block can accept a byte.
REQ-008 The block SHALL have port tx_serial  output  1  UART line, idle high, registered.
REQ-009 The block SHALL have port tx_busy  output  1  high while a frame is in progress, i.e. the complement of tx_ready.

Function
REQ-010 The block SHALL implement the states IDLE, START, DATA, PARITY, STOP in a single FSM.
REQ-011 In IDLE: tx_ready = 1 and tx_serial = 1.
REQ-012 A byte SHALL be accepted only on a rising edge with tx_valid = 1 and tx_ready = 1; on acceptance tx_data is latched into an internal shift register and the state moves to START.
REQ-013 tx_valid while not in IDLE SHALL be ignored; changes to tx_data after acceptance SHALL have no effect on the frame in progress.
REQ-014 START: tx_serial = 0 for exactly CLKS_PER_BIT cycles, beginning the cycle after acceptance.
REQ-015 DATA: 8 bits sent LSB first, each held for exactly CLKS_PER_BIT cycles; bit index counter runs 0..7.
REQ-016 PARITY, when compiled in: one bit held for CLKS_PER_BIT cycles; otherwise the FSM goes from DATA directly to STOP.
REQ-017 STOP: tx_serial = 1 for STOP_BITS*CLKS_PER_BIT cycles, then the FSM returns to IDLE.
REQ-018 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL count 0..CLKS_PER_BIT-1, and SHALL restart at 0 on every state or bit transition; no drift across a frame.
REQ-019 Back-to-back: with tx_valid held high, the frame period SHALL be (10 + parity + STOP_BITS - 1)*CLKS_PER_BIT + 1 cycles, including one IDLE cycle between frames.
REQ-020 tx_ready SHALL drop in the cycle after acceptance and rise in the first IDLE cycle after STOP completes.

Reset
REQ-021 RESET asserted SHALL force, immediately and independently of CLOCK: state = IDLE, tx_serial = 1, tx_ready = 1, tx_busy = 0, counters = 0, shift register = 0.
REQ-022 RESET mid-frame SHALL discard the byte in flight, with no partial stop bit; the first acceptance can occur on the first CLOCK edge after RESET deasserts.

Configuration
REQ-023 With macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be sent after bit 7.
REQ-024 With UART_TX_PARITY_EN undefined: there SHALL be no PARITY state logic and frames are 8N1 (or 8N2).

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state encoding constants, the default CLKS_PER_BIT, and the data width (8), for reuse by the receive side.
REQ-026 A single sub-module uart_baud_tick SHALL generate a one-cycle bit-end pulse from CLKS_PER_BIT, with restart input driven by the FSM.

Verification (CLKS_PER_BIT = 4, STOP_BITS = 1 unless stated)
REQ-027 Send 0xA5 -> line reads start 0, then 1,0,1,0,0,1,0,1, stop 1, each bit 4 cycles; tx_ready low for 40 cycles.
REQ-028 Hold tx_valid high with bytes 0x00 then 0xFF -> two frames 41 cycles apart; second frame data all 1s.
REQ-029 Pulse tx_valid with 0x3C at cycle 10 of a frame in progress -> ignored; no extra frame; current frame unchanged.
REQ-030 Assert RESET at cycle 15 of a 0x55 frame -> tx_serial = 1 at once, tx_ready = 1, and the next byte (0x81) is sent cleanly.
REQ-031 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after bit 7, frame 44 cycles; send 0x03 -> parity bit 0.
REQ-032 STOP_BITS = 2, CLKS_PER_BIT = 2, send 0x80 -> stop high for 4 cycles; back-to-back period 23 cycles.
